// File: rtl/date_to_posix_time_if.sv
// Request/result bundle between a date-field producer and the date-to-POSIX converter.
interface date_to_posix_time_if #(
   parameter int unsigned YEAR_W = 12
);
   logic              date_valid_i;
   logic [YEAR_W-1:0] year_i;
   logic [3:0]        month_i;
   logic [4:0]        day_i;
   logic [4:0]        hour_i;
   logic [5:0]        min_i;
   logic [5:0]        sec_i;
   logic              busy_o;
   logic [31:0]       posix_time_o;
   logic              posix_time_en_o;
   logic [2:0]        wday_o;
   logic              err_o;

   modport master (
      output date_valid_i, year_i, month_i, day_i, hour_i, min_i, sec_i,
      input  busy_o, posix_time_o, posix_time_en_o, wday_o, err_o
   );

   modport slave (
      input  date_valid_i, year_i, month_i, day_i, hour_i, min_i, sec_i,
      output busy_o, posix_time_o, posix_time_en_o, wday_o, err_o
   );
endinterface

// File: rtl/date_to_posix_time.sv
// Converts a broken-down calendar date/time into a 32-bit POSIX second count and weekday,
// accumulating one year or one month of days per clock.
module date_to_posix_time #(
   parameter int unsigned FIRST_YEAR = 1970,
   parameter int unsigned MAX_YEAR   = 2105,
   parameter int unsigned YEAR_W     = 12
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   date_to_posix_time_if.slave  bus
);

   localparam int unsigned ACC_W = 17;

   typedef enum logic [1:0] {IDLE, YEARS, MONTHS, CALC} state_t;

   function automatic logic is_leap(input logic [YEAR_W-1:0] y);
      return (y[1:0] == 2'b00) &&
             (((y % YEAR_W'(100)) != '0) || ((y % YEAR_W'(400)) == '0));
   endfunction

   function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
      case (m)
         4'd1:                   return leap ? 5'd29 : 5'd28;
         4'd3, 4'd5, 4'd8, 4'd10: return 5'd30;
         default:                return 5'd31;
      endcase
   endfunction

   state_t            state_q, state_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [YEAR_W-1:0] yr_cnt_q, yr_cnt_d;
   logic [3:0]        mo_cnt_q, mo_cnt_d;
   logic [YEAR_W-1:0] year_q, year_d;
   logic [3:0]        month_q, month_d;
   logic [4:0]        day_q, day_d;
   logic [4:0]        hour_q, hour_d;
   logic [5:0]        min_q, min_d;
   logic [5:0]        sec_q, sec_d;
   logic              busy_q, busy_d;
   logic [31:0]       posix_q, posix_d;
   logic              en_q, en_d;
   logic [2:0]        wday_q, wday_d;
   logic              err_q, err_d;

   logic              req_bad;
   logic [ACC_W-1:0]  days;
   logic [ACC_W-1:0]  wday_sum;
   logic [31:0]       secs_total;

   // Request validation, evaluated on the live inputs while idle
   assign req_bad = (bus.year_i < YEAR_W'(FIRST_YEAR)) || (bus.year_i > YEAR_W'(MAX_YEAR)) ||
                    (bus.month_i > 4'd11) ||
                    (bus.day_i >= month_len(bus.month_i, is_leap(bus.year_i))) ||
                    (bus.hour_i > 5'd23) || (bus.min_i > 6'd59) || (bus.sec_i > 6'd59);

   // Final combine used in CALC; all terms fit comfortably in 32 bits
   assign days       = acc_q + ACC_W'(day_q);
   assign wday_sum   = (days + ACC_W'(3)) % ACC_W'(7);
   assign secs_total = 32'(days) * 32'd86400 + 32'(hour_q) * 32'd3600 +
                       32'(min_q) * 32'd60 + 32'(sec_q);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         yr_cnt_q <= YEAR_W'(FIRST_YEAR);
         mo_cnt_q <= '0;
         year_q   <= '0;
         month_q  <= '0;
         day_q    <= '0;
         hour_q   <= '0;
         min_q    <= '0;
         sec_q    <= '0;
         busy_q   <= 1'b0;
         posix_q  <= '0;
         en_q     <= 1'b0;
         wday_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         yr_cnt_q <= yr_cnt_d;
         mo_cnt_q <= mo_cnt_d;
         year_q   <= year_d;
         month_q  <= month_d;
         day_q    <= day_d;
         hour_q   <= hour_d;
         min_q    <= min_d;
         sec_q    <= sec_d;
         busy_q   <= busy_d;
         posix_q  <= posix_d;
         en_q     <= en_d;
         wday_q   <= wday_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      yr_cnt_d = yr_cnt_q;
      mo_cnt_d = mo_cnt_q;
      year_d   = year_q;
      month_d  = month_q;
      day_d    = day_q;
      hour_d   = hour_q;
      min_d    = min_q;
      sec_d    = sec_q;
      busy_d   = busy_q;
      posix_d  = posix_q;
      wday_d   = wday_q;
      en_d     = 1'b0;
      err_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.date_valid_i) begin
               if (req_bad) begin
                  err_d = 1'b1;
               end else begin
                  year_d   = bus.year_i;
                  month_d  = bus.month_i;
                  day_d    = bus.day_i;
                  hour_d   = bus.hour_i;
                  min_d    = bus.min_i;
                  sec_d    = bus.sec_i;
                  acc_d    = '0;
                  yr_cnt_d = YEAR_W'(FIRST_YEAR);
                  mo_cnt_d = '0;
                  busy_d   = 1'b1;
                  state_d  = YEARS;
               end
            end
         end
         YEARS: begin
            if (yr_cnt_q < year_q) begin
               acc_d    = acc_q + (is_leap(yr_cnt_q) ? ACC_W'(366) : ACC_W'(365));
               yr_cnt_d = yr_cnt_q + YEAR_W'(1);
            end else begin
               state_d = MONTHS;
            end
         end
         MONTHS: begin
            if (mo_cnt_q < month_q) begin
               acc_d    = acc_q + ACC_W'(month_len(mo_cnt_q, is_leap(year_q)));
               mo_cnt_d = mo_cnt_q + 4'd1;
            end else begin
               state_d = CALC;
            end
         end
         CALC: begin
            posix_d = secs_total;
            wday_d  = 3'(wday_sum);
            en_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.busy_o          = busy_q;
   assign bus.posix_time_o    = posix_q;
   assign bus.posix_time_en_o = en_q;
   assign bus.wday_o          = wday_q;
   assign bus.err_o           = err_q;

endmodule

// File: tb/tb_date_to_posix_time.sv
// Scoreboard bench for date_to_posix_time: expected results come from a closed-form civil-date model.
module tb_date_to_posix_time;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   date_to_posix_time_if #(.YEAR_W(12)) bus();

   date_to_posix_time #(.FIRST_YEAR(1970), .MAX_YEAR(2105), .YEAR_W(12)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] t;
      logic [2:0]  w;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   // Days since 1970-01-01 via the closed-form civil-date formula (month/day 0-based)
   function automatic int model_days(input int y, input int mo, input int d);
      int m, yy, era, yoe, mp, doy, doe;
      m   = mo + 1;
      yy  = (m <= 2) ? y - 1 : y;
      era = yy / 400;
      yoe = yy - era * 400;
      mp  = (m > 2) ? m - 3 : m + 9;
      doy = (153 * mp + 2) / 5 + d;
      doe = yoe * 365 + yoe / 4 - yoe / 100 + doy;
      return era * 146097 + doe - 719468;
   endfunction

   task automatic drive(input int y, input int mo, input int d, input int h, input int mi, input int s);
      bus.date_valid_i = 1'b1;
      bus.year_i  = 12'(y);
      bus.month_i = 4'(mo);
      bus.day_i   = 5'(d);
      bus.hour_i  = 5'(h);
      bus.min_i   = 6'(mi);
      bus.sec_i   = 6'(s);
   endtask

   // Drives a one-cycle request; valid ones push their expected result
   task automatic send(input int y, input int mo, input int d, input int h, input int mi, input int s,
                       input bit ok);
      exp_t   e;
      longint secs;
      drive(y, mo, d, h, mi, s);
      if (ok) begin
         secs  = longint'(model_days(y, mo, d)) * 86400 + h * 3600 + mi * 60 + s;
         e.t   = 32'(secs);
         e.w   = 3'((model_days(y, mo, d) + 3) % 7);
         e.lat = (y - 1970) + mo + 3;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      bus.date_valid_i = 1'b0;
   endtask

   task automatic wait_result(output logic [31:0] t, output logic [2:0] w, output int cyc,
                              output int bcnt, output bit to);
      cyc = 0; bcnt = 0; to = 1'b1; t = '0; w = '0;
      for (int i = 0; i < 400; i++) begin
         if (bus.busy_o) bcnt++;
         if (bus.posix_time_en_o) begin
            t = bus.posix_time_o; w = bus.wday_o; to = 1'b0;
            break;
         end
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      total++;
      if ({bus.busy_o, bus.posix_time_en_o, bus.err_o, bus.wday_o, bus.posix_time_o} !== 37'd0) begin
         bad++;
         $display("FAIL reset_outputs got busy=%b en=%b err=%b wday=%0d t=%0d want all 0",
                  bus.busy_o, bus.posix_time_en_o, bus.err_o, bus.wday_o, bus.posix_time_o);
      end
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_epoch();
      logic [31:0] t; logic [2:0] w; int cyc, bcnt; bit to; exp_t e;
      send(1970, 0, 0, 0, 0, 0, 1'b1);
      wait_result(t, w, cyc, bcnt, to);
      e = sb.pop_front();
      total++; if (to) begin bad++; $display("FAIL epoch_timeout no posix_time_en_o"); end
      total++; if (t !== e.t) begin bad++; $display("FAIL epoch_time got %0d want %0d", t, e.t); end
      total++; if (w !== e.w) begin bad++; $display("FAIL epoch_wday got %0d want %0d", w, e.w); end
      total++; if (cyc !== e.lat) begin bad++; $display("FAIL epoch_latency got %0d want %0d", cyc, e.lat); end
      total++; if (bcnt !== e.lat) begin bad++; $display("FAIL epoch_busy got %0d want %0d", bcnt, e.lat); end
      @(posedge clk); #1;
   endtask

   task automatic test_century_leap();
      logic [31:0] t; logic [2:0] w; int cyc, bcnt; bit to; exp_t e;
      send(2000, 2, 0, 0, 0, 0, 1'b1);
      wait_result(t, w, cyc, bcnt, to);
      e = sb.pop_front();
      total++; if (to) begin bad++; $display("FAIL century_timeout no posix_time_en_o"); end
      total++; if (t !== e.t) begin bad++; $display("FAIL century_time got %0d want %0d", t, e.t); end
      total++; if (w !== e.w) begin bad++; $display("FAIL century_wday got %0d want %0d", w, e.w); end
      total++; if (cyc !== e.lat) begin bad++; $display("FAIL century_latency got %0d want %0d", cyc, e.lat); end
      total++; if (bcnt !== e.lat) begin bad++; $display("FAIL century_busy got %0d want %0d", bcnt, e.lat); end
      @(posedge clk); #1;
   endtask

   task automatic test_leap_day();
      logic [31:0] t; logic [2:0] w; int cyc, bcnt; bit to; exp_t e;
      send(2024, 1, 28, 12, 34, 56, 1'b1);
      wait_result(t, w, cyc, bcnt, to);
      e = sb.pop_front();
      total++; if (to) begin bad++; $display("FAIL leapday_timeout no posix_time_en_o"); end
      total++; if (t !== e.t) begin bad++; $display("FAIL leapday_time got %0d want %0d", t, e.t); end
      total++; if (w !== e.w) begin bad++; $display("FAIL leapday_wday got %0d want %0d", w, e.w); end
      total++; if (cyc !== e.lat) begin bad++; $display("FAIL leapday_latency got %0d want %0d", cyc, e.lat); end
      @(posedge clk); #1;
   endtask

   task automatic test_upper_bound();
      logic [31:0] t; logic [2:0] w; int cyc, bcnt; bit to; exp_t e;
      int bad_years[2] = '{2106, 1969};
      bit saw_en;
      send(2105, 11, 30, 23, 59, 59, 1'b1);
      wait_result(t, w, cyc, bcnt, to);
      e = sb.pop_front();
      total++; if (to) begin bad++; $display("FAIL upper_timeout no posix_time_en_o"); end
      total++; if (t !== e.t) begin bad++; $display("FAIL upper_time got %0d want %0d", t, e.t); end
      total++; if (w !== e.w) begin bad++; $display("FAIL upper_wday got %0d want %0d", w, e.w); end
      total++; if (cyc !== e.lat) begin bad++; $display("FAIL upper_latency got %0d want %0d", cyc, e.lat); end
      @(posedge clk); #1;
      foreach (bad_years[i]) begin
         send(bad_years[i], 0, 0, 0, 0, 0, 1'b0);
         total++;
         if (bus.err_o !== 1'b1 || bus.busy_o !== 1'b0) begin
            bad++;
            $display("FAIL year_err_%0d got err=%b busy=%b want err=1 busy=0", bad_years[i], bus.err_o, bus.busy_o);
         end
         saw_en = 1'b0;
         @(posedge clk); #1;
         total++;
         if (bus.err_o !== 1'b0) begin bad++; $display("FAIL year_err_width_%0d err still %b want 0", bad_years[i], bus.err_o); end
         for (int c = 0; c < 5; c++) begin
            if (bus.posix_time_en_o || bus.busy_o) saw_en = 1'b1;
            @(posedge clk); #1;
         end
         total++;
         if (saw_en || bus.posix_time_o !== e.t || bus.wday_o !== e.w) begin
            bad++;
            $display("FAIL year_hold_%0d got en_or_busy=%b t=%0d wday=%0d want 0 %0d %0d",
                     bad_years[i], saw_en, bus.posix_time_o, bus.wday_o, e.t, e.w);
         end
      end
   endtask

   task automatic test_invalid_fields();
      int ys[4] = '{2023, 2023, 2023, 2023};
      int ms[4] = '{1, 12, 5, 5};
      int ds[4] = '{28, 0, 3, 3};
      int hs[4] = '{0, 0, 24, 10};
      int ss[4] = '{0, 0, 0, 60};
      bit busy_seen;
      for (int i = 0; i < 4; i++) begin
         send(ys[i], ms[i], ds[i], hs[i], 0, ss[i], 1'b0);
         total++;
         if (bus.err_o !== 1'b1 || bus.busy_o !== 1'b0) begin
            bad++;
            $display("FAIL field_err_%0d got err=%b busy=%b want err=1 busy=0", i, bus.err_o, bus.busy_o);
         end
         busy_seen = 1'b0;
         for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (bus.busy_o || bus.posix_time_en_o || bus.err_o) busy_seen = 1'b1;
         end
         total++;
         if (busy_seen) begin bad++; $display("FAIL field_quiet_%0d got activity=1 want 0", i); end
      end
   endtask

   task automatic test_busy_ignore();
      logic [31:0] t; logic [2:0] w; int cyc, bcnt; bit to; exp_t e;
      send(2024, 1, 28, 12, 34, 56, 1'b1);
      repeat (5) begin @(posedge clk); #1; end
      drive(1980, 3, 4, 5, 6, 7);
      @(posedge clk); #1;
      bus.date_valid_i = 1'b0;
      wait_result(t, w, cyc, bcnt, to);
      e = sb.pop_front();
      total++; if (to) begin bad++; $display("FAIL ignore_timeout no posix_time_en_o"); end
      total++; if (t !== e.t) begin bad++; $display("FAIL ignore_time got %0d want %0d", t, e.t); end
      total++; if (w !== e.w) begin bad++; $display("FAIL ignore_wday got %0d want %0d", w, e.w); end
      total++; if (cyc + 6 !== e.lat) begin bad++; $display("FAIL ignore_latency got %0d want %0d", cyc + 6, e.lat); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      logic [31:0] t; logic [2:0] w; int cyc, bcnt; bit to; exp_t e; bit saw_en;
      send(2050, 5, 10, 1, 2, 3, 1'b1);
      repeat (10) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      total++;
      if ({bus.busy_o, bus.posix_time_en_o, bus.err_o, bus.wday_o, bus.posix_time_o} !== 37'd0) begin
         bad++;
         $display("FAIL midreset_outputs got busy=%b en=%b err=%b wday=%0d t=%0d want all 0",
                  bus.busy_o, bus.posix_time_en_o, bus.err_o, bus.wday_o, bus.posix_time_o);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      void'(sb.pop_front());
      saw_en = 1'b0;
      for (int c = 0; c < 100; c++) begin
         if (bus.posix_time_en_o || bus.busy_o) saw_en = 1'b1;
         @(posedge clk); #1;
      end
      total++; if (saw_en) begin bad++; $display("FAIL midreset_quiet got activity=1 want 0"); end
      send(1999, 11, 30, 23, 59, 59, 1'b1);
      wait_result(t, w, cyc, bcnt, to);
      e = sb.pop_front();
      total++; if (to) begin bad++; $display("FAIL afterreset_timeout no posix_time_en_o"); end
      total++; if (t !== e.t) begin bad++; $display("FAIL afterreset_time got %0d want %0d", t, e.t); end
      total++; if (w !== e.w) begin bad++; $display("FAIL afterreset_wday got %0d want %0d", w, e.w); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [31:0] t; logic [2:0] w; int cyc, bcnt; bit to; exp_t e;
      send(1985, 6, 14, 8, 30, 15, 1'b1);
      wait_result(t, w, cyc, bcnt, to);
      e = sb.pop_front();
      total++; if (to) begin bad++; $display("FAIL b2b_a_timeout no posix_time_en_o"); end
      total++; if (t !== e.t) begin bad++; $display("FAIL b2b_a_time got %0d want %0d", t, e.t); end
      total++; if (w !== e.w) begin bad++; $display("FAIL b2b_a_wday got %0d want %0d", w, e.w); end
      send(2012, 1, 28, 0, 0, 1, 1'b1);
      wait_result(t, w, cyc, bcnt, to);
      e = sb.pop_front();
      total++; if (to) begin bad++; $display("FAIL b2b_b_timeout no posix_time_en_o"); end
      total++; if (t !== e.t) begin bad++; $display("FAIL b2b_b_time got %0d want %0d", t, e.t); end
      total++; if (w !== e.w) begin bad++; $display("FAIL b2b_b_wday got %0d want %0d", w, e.w); end
      total++; if (cyc !== e.lat) begin bad++; $display("FAIL b2b_b_latency got %0d want %0d", cyc, e.lat); end
      @(posedge clk); #1;
   endtask

   initial begin
      bus.date_valid_i = 1'b0;
      bus.year_i  = '0;
      bus.month_i = '0;
      bus.day_i   = '0;
      bus.hour_i  = '0;
      bus.min_i   = '0;
      bus.sec_i   = '0;
      @(posedge clk); #1;
      test_reset();
      test_epoch();
      test_century_leap();
      test_leap_day();
      test_upper_bound();
      test_invalid_fields();
      test_busy_ignore();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
